bg_layer_renderer: RTL and testbench

- Parametrised, scrollable background-layer renderer for the VGA path.
- Maps the current DrawX/DrawY to a source-image address with integer pixel replication and wrap-around scroll.
- Drives an external 1-cycle-class image ROM and a combinational palette, and returns registered RGB aligned with a delayed blank.
- Scroll offsets are double-buffered and commit only at frame start, so a frame never tears.

---
 rtl/bg_layer_renderer.sv | 162 ++++++++++++++++
 tb/tb_bg_layer_renderer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bg_layer_renderer.sv
// Scrollable, pixel-replicated background layer: DrawX/DrawY -> ROM address -> palette -> registered RGB.
// Latency: ROM_LAT+2 cycles from DrawX/DrawY/blank to red/green/blue/pix_active.
// Backpressure: none; a free-running pixel pipeline. Optional colour key via macro BG_TRANSPARENT_KEY_EN.
module bg_layer_renderer #(
  parameter int IMG_W           = 640,
  parameter int IMG_H           = 480,
  parameter int SCALE_SHIFT     = 0,
  parameter int IDX_W           = 4,
  parameter int ADDR_W          = 19,
  parameter int ROM_LAT         = 1,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        scroll_x_in,
  input  logic [9:0]        scroll_y_in,
  input  logic              scroll_we,
  output logic              scroll_pending,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              pix_active,
  output logic              transparent
);

  localparam logic [10:0] W11 = 11'(IMG_W);
  localparam logic [10:0] H11 = 11'(IMG_H);
  // Worst-case number of subtractions needed to fold the scaled coordinate into the image.
  localparam int NSUB_X = (1023 >> SCALE_SHIFT) / IMG_W;
  localparam int NSUB_Y = (1023 >> SCALE_SHIFT) / IMG_H;

  logic [9:0]        ax, ay;
  logic [9:0]        shadow_x, shadow_y;
  logic              commit;
  logic              write_ok;
  logic [9:0]        eff_x, eff_y;
  logic [10:0]       ux, uy, sx, sy;
  logic [ADDR_W-1:0] addr_next;
  logic [ROM_LAT:0]  blank_dly;
  logic              blank_at_pal;

  // Commit happens at the top-left pixel; that pixel already uses the new offsets.
  assign commit   = (DrawX == 10'd0) && (DrawY == 10'd0) && scroll_pending;
  assign write_ok = scroll_we && ({1'b0, scroll_x_in} < W11) && ({1'b0, scroll_y_in} < H11);
  assign eff_x    = commit ? shadow_x : ax;
  assign eff_y    = commit ? shadow_y : ay;

  assign pal_index    = rom_q;
  assign blank_at_pal = blank_dly[ROM_LAT];

  // Scale, fold into the image by compare-subtract, add scroll with a single wrap, form the address.
  always_comb begin
    ux = {1'b0, DrawX >> SCALE_SHIFT};
    uy = {1'b0, DrawY >> SCALE_SHIFT};
    for (int i = 0; i < NSUB_X; i++) begin
      if (ux >= W11) ux = ux - W11;
    end
    for (int j = 0; j < NSUB_Y; j++) begin
      if (uy >= H11) uy = uy - H11;
    end
    sx = ux + {1'b0, eff_x};
    if (sx >= W11) sx = sx - W11;
    sy = uy + {1'b0, eff_y};
    if (sy >= H11) sy = sy - H11;
    addr_next = ADDR_W'(32'(sy) * IMG_W + 32'(sx));
  end

  // Scroll shadow/active registers; a write in the commit cycle stays pending for the next frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      ax             <= '0;
      ay             <= '0;
      shadow_x       <= '0;
      shadow_y       <= '0;
      scroll_pending <= 1'b0;
    end else begin
      if (commit) begin
        ax <= shadow_x;
        ay <= shadow_y;
      end
      if (write_ok) begin
        shadow_x       <= scroll_x_in;
        shadow_y       <= scroll_y_in;
        scroll_pending <= 1'b1;
      end else if (commit) begin
        scroll_pending <= 1'b0;
      end
    end
  end

  // Stage 0 address register and the blank tracker that follows each pixel to the colour stage.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      blank_dly   <= '0;
    end else begin
      rom_address <= addr_next;
      blank_dly   <= {blank_dly[ROM_LAT-1:0], blank};
    end
  end

`ifdef BG_TRANSPARENT_KEY_EN
  logic key_hit;
  assign key_hit = blank_at_pal && (rom_q == IDX_W'(TRANSPARENT_IDX));

  // Colour register: keyed pixels go black and flag transparency for the compositor.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pix_active  <= 1'b0;
      transparent <= 1'b0;
    end else begin
      pix_active  <= blank_at_pal;
      transparent <= key_hit;
      if (blank_at_pal && !key_hit) begin
        red   <= pal_red;
        green <= pal_green;
        blue  <= pal_blue;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
`else
  assign transparent = 1'b0;

  // Colour register: palette colour during active video, black otherwise.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      pix_active <= 1'b0;
    end else begin
      pix_active <= blank_at_pal;
      if (blank_at_pal) begin
        red   <= pal_red;
        green <= pal_green;
        blue  <= pal_blue;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bg_layer_renderer.sv
// Bench for bg_layer_renderer: two instances (unscaled ROM_LAT=1, 2x-scaled ROM_LAT=2) share stimulus.
// Latency: model expects address one edge after input and colour ROM_LAT+2 edges after input.
// Backpressure: none; directed cases then randomized pixels, scroll writes and resets.
module tb_bg_layer_renderer;

  localparam int W0 = 640, H0 = 480, S0 = 0, L0 = 1;
  localparam int W1 = 640, H1 = 480, S1 = 1, L1 = 2;
  localparam int KEY = 0;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] draw_x = '0, draw_y = '0;
  logic       blank = 1'b0;
  logic [9:0] sx_in = '0, sy_in = '0;
  logic       we = 1'b0;

  logic [18:0] rom_addr [2];
  logic [3:0]  rom_q [2], pal_idx [2], pr [2], pg [2], pb [2], r [2], g [2], b [2];
  logic        pend [2], pix [2], tr [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  bg_layer_renderer #(.IMG_W(W0), .IMG_H(H0), .SCALE_SHIFT(S0), .IDX_W(4), .ADDR_W(19),
                      .ROM_LAT(L0), .TRANSPARENT_IDX(KEY)) dut0 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .scroll_x_in(sx_in), .scroll_y_in(sy_in), .scroll_we(we), .scroll_pending(pend[0]),
    .rom_address(rom_addr[0]), .rom_q(rom_q[0]), .pal_index(pal_idx[0]),
    .pal_red(pr[0]), .pal_green(pg[0]), .pal_blue(pb[0]),
    .red(r[0]), .green(g[0]), .blue(b[0]), .pix_active(pix[0]), .transparent(tr[0]));

  bg_layer_renderer #(.IMG_W(W1), .IMG_H(H1), .SCALE_SHIFT(S1), .IDX_W(4), .ADDR_W(19),
                      .ROM_LAT(L1), .TRANSPARENT_IDX(KEY)) dut1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .scroll_x_in(sx_in), .scroll_y_in(sy_in), .scroll_we(we), .scroll_pending(pend[1]),
    .rom_address(rom_addr[1]), .rom_q(rom_q[1]), .pal_index(pal_idx[1]),
    .pal_red(pr[1]), .pal_green(pg[1]), .pal_blue(pb[1]),
    .red(r[1]), .green(g[1]), .blue(b[1]), .pix_active(pix[1]), .transparent(tr[1]));

  // Image ROM contents: a fixed scramble of the address.
  function automatic logic [3:0] rom_fn(input logic [18:0] a);
    logic [18:0] t;
    t = a ^ (a >> 4) ^ (a >> 9) ^ (a >> 13);
    return t[3:0];
  endfunction

  // External ROMs with the instance's read latency.
  logic [3:0] rp0, rp1a, rp1b;
  always @(posedge vga_clk) begin
    rp0  <= rom_fn(rom_addr[0]);
    rp1a <= rom_fn(rom_addr[1]);
    rp1b <= rp1a;
  end
  assign rom_q[0] = rp0;
  assign rom_q[1] = rp1b;

  // Combinational palettes.
  assign pr[0] = pal_idx[0];
  assign pg[0] = ~pal_idx[0];
  assign pb[0] = pal_idx[0] ^ 4'hA;
  assign pr[1] = pal_idx[1];
  assign pg[1] = ~pal_idx[1];
  assign pb[1] = pal_idx[1] ^ 4'hA;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference state: scroll registers and per-edge history of {blank, address}.
  int          m_ax [2], m_ay [2], m_shx [2], m_shy [2];
  logic        m_pend [2];
  logic [19:0] hist [2][8];
  int          hcnt [2];

  task automatic tick();
    int          w, h, s, l, ex, ey, cx, cy;
    logic        cm;
    int          e_addr [2];
    logic [3:0]  e_r [2], e_g [2], e_b [2], idx;
    logic        e_pix [2], e_tr [2];
    logic [19:0] ent;
    for (int k = 0; k < 2; k++) begin
      w = k ? W1 : W0;
      h = k ? H1 : H0;
      s = k ? S1 : S0;
      l = k ? L1 : L0;
      if (reset) begin
        m_ax[k] = 0; m_ay[k] = 0; m_shx[k] = 0; m_shy[k] = 0;
        m_pend[k] = 1'b0;
        hcnt[k] = 0;
        e_addr[k] = 0;
      end else begin
        cm = (draw_x == 0) && (draw_y == 0) && m_pend[k];
        ex = cm ? m_shx[k] : m_ax[k];
        ey = cm ? m_shy[k] : m_ay[k];
        cx = ((int'(draw_x) >> s) % w + ex) % w;
        cy = ((int'(draw_y) >> s) % h + ey) % h;
        e_addr[k] = cy * w + cx;
        if (cm) begin
          m_ax[k] = m_shx[k];
          m_ay[k] = m_shy[k];
        end
        if (we && int'(sx_in) < w && int'(sy_in) < h) begin
          m_shx[k] = int'(sx_in);
          m_shy[k] = int'(sy_in);
          m_pend[k] = 1'b1;
        end else if (cm) begin
          m_pend[k] = 1'b0;
        end
        for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = {blank, 19'(e_addr[k])};
        if (hcnt[k] < 8) hcnt[k]++;
      end
      e_r[k] = '0; e_g[k] = '0; e_b[k] = '0; e_pix[k] = 1'b0; e_tr[k] = 1'b0;
      if (!reset && hcnt[k] >= l + 2) begin
        ent = hist[k][l+1];
        if (ent[19]) begin
          e_pix[k] = 1'b1;
          idx = rom_fn(ent[18:0]);
`ifdef BG_TRANSPARENT_KEY_EN
          if (idx == 4'(KEY)) begin
            e_tr[k] = 1'b1;
          end else begin
            e_r[k] = idx; e_g[k] = ~idx; e_b[k] = idx ^ 4'hA;
          end
`else
          e_r[k] = idx; e_g[k] = ~idx; e_b[k] = idx ^ 4'hA;
`endif
        end
      end
    end
    @(posedge vga_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("addr%0d", k), 32'(rom_addr[k]), 32'(e_addr[k]));
      check($sformatf("pend%0d", k), 32'(pend[k]), 32'(m_pend[k]));
      check($sformatf("red%0d", k), 32'(r[k]), 32'(e_r[k]));
      check($sformatf("green%0d", k), 32'(g[k]), 32'(e_g[k]));
      check($sformatf("blue%0d", k), 32'(b[k]), 32'(e_b[k]));
      check($sformatf("pix%0d", k), 32'(pix[k]), 32'(e_pix[k]));
      check($sformatf("transp%0d", k), 32'(tr[k]), 32'(e_tr[k]));
    end
  endtask

  task automatic drive(input int x, input int y, input logic bl, input logic w_en,
                       input int wx, input int wy);
    draw_x = 10'(x);
    draw_y = 10'(y);
    blank  = bl;
    we     = w_en;
    sx_in  = 10'(wx);
    sy_in  = 10'(wy);
    tick();
  endtask

  initial begin
    // Reset for 3 cycles with active video.
    reset = 1'b1;
    blank = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_addr", 32'(rom_addr[0]), 0);
    check("rst_red", 32'(r[0]), 0);
    check("rst_pix", 32'(pix[0]), 0);
    check("rst_pend", 32'(pend[0]), 0);
    reset = 1'b0;

    // Unscaled mapping and pipeline latency.
    drive(5, 2, 1'b1, 1'b0, 0, 0);
    check("addr_5_2", 32'(rom_addr[0]), 1285);
    drive(6, 2, 1'b1, 1'b0, 0, 0);
    drive(7, 2, 1'b1, 1'b0, 0, 0);
    check("colour_5_2", 32'(r[0]), 32'(rom_fn(19'd1285)));
    check("pix_5_2", 32'(pix[0]), 1);

    // 2x replication: neighbouring columns share a source pixel.
    drive(10, 6, 1'b1, 1'b0, 0, 0);
    check("scaled_10_6", 32'(rom_addr[1]), 1925);
    drive(11, 6, 1'b1, 1'b0, 0, 0);
    check("scaled_11_6", 32'(rom_addr[1]), 1925);

    // Horizontal scroll of 600 with wrap.
    drive(100, 3, 1'b1, 1'b1, 600, 0);
    check("pend_after_we", 32'(pend[0]), 1);
    drive(0, 0, 1'b1, 1'b0, 0, 0);
    check("commit_0_0", 32'(rom_addr[0]), 600);
    drive(100, 0, 1'b1, 1'b0, 0, 0);
    check("wrap_100", 32'(rom_addr[0]), 60);
    drive(39, 0, 1'b1, 1'b0, 0, 0);
    check("wrap_39", 32'(rom_addr[0]), 639);

    // Mid-frame write holds off until frame start; out-of-range write ignored.
    drive(200, 100, 1'b1, 1'b1, 3, 4);
    drive(201, 100, 1'b1, 1'b0, 0, 0);
    check("no_tear", 32'(rom_addr[0]), 100 * 640 + 161);
    drive(50, 50, 1'b1, 1'b1, 640, 0);
    check("bad_we_pend", 32'(pend[0]), 1);
    drive(0, 0, 1'b1, 1'b0, 0, 0);
    check("commit_3_4", 32'(rom_addr[0]), 2563);
    check("pend_cleared", 32'(pend[0]), 0);

    // Write colliding with commit: old shadow commits, new one waits a frame.
    drive(7, 7, 1'b1, 1'b1, 10, 20);
    drive(0, 0, 1'b1, 1'b1, 30, 40);
    check("collide_addr", 32'(rom_addr[0]), 20 * 640 + 10);
    check("collide_pend", 32'(pend[0]), 1);
    drive(0, 0, 1'b0, 1'b0, 0, 0);
    check("next_commit", 32'(rom_addr[0]), 40 * 640 + 30);
    drive(5, 5, 1'b1, 1'b1, 0, 480);
    check("bad_y_pend", 32'(pend[0]), 0);

    // Randomized pixels, writes (some out of range), blanking and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) begin
        draw_x = '0;
        draw_y = '0;
      end else begin
        draw_x = 10'($urandom_range(0, 1023));
        draw_y = 10'($urandom_range(0, 1023));
      end
      blank = ($urandom_range(0, 4) != 0);
      we    = ($urandom_range(0, 7) == 0);
      sx_in = 10'($urandom_range(0, 700));
      sy_in = 10'($urandom_range(0, 520));
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
